// File: rtl/buyruk_getir_if.sv
`default_nettype none
// ============================================================================
//  Module      : buyruk_getir_if
//  Description : Bus bundle for the instruction-fetch front end: the read-only
//                memory port towards anabellek and the valid/ready instruction
//                port towards the islemci core, plus the redirect request.
//  Revision    : 1.0 - initial release
// ============================================================================
interface buyruk_getir_if #(
    parameter int ADRES_BIT = 32,
    parameter int VERI_BIT  = 32
);
    // Memory side
    logic [ADRES_BIT-1:0] bellek_adres;
    logic                 bellek_oku_istek;
    logic [VERI_BIT-1:0]  bellek_oku_veri;

    // Core side
    logic [VERI_BIT-1:0]  buyruk;
    logic [ADRES_BIT-1:0] buyruk_pc;
    logic                 buyruk_gecerli;
    logic                 buyruk_hazir;
    logic                 yonlendir;
    logic [ADRES_BIT-1:0] yonlendir_adres;

    // Fetch unit view
    modport master (
        output bellek_adres,
        output bellek_oku_istek,
        input  bellek_oku_veri,
        output buyruk,
        output buyruk_pc,
        output buyruk_gecerli,
        input  buyruk_hazir,
        input  yonlendir,
        input  yonlendir_adres
    );

    // Environment view (memory model plus core)
    modport slave (
        input  bellek_adres,
        input  bellek_oku_istek,
        output bellek_oku_veri,
        input  buyruk,
        input  buyruk_pc,
        input  buyruk_gecerli,
        output buyruk_hazir,
        output yonlendir,
        output yonlendir_adres
    );
endinterface
`default_nettype wire

// File: rtl/buyruk_getir.sv
`default_nettype none
// ============================================================================
//  Module      : buyruk_getir
//  Description : Instruction-fetch front end. Reads words sequentially from
//                anabellek, buffers {pc, instruction} pairs in a small FIFO and
//                hands them to the core over valid/ready. A redirect flushes
//                the buffer and restarts fetch at the (word-aligned) target.
//  Revision    : 1.0 - initial release
// ============================================================================
module buyruk_getir #(
    parameter logic [31:0] BASLANGIC_ADRES = 32'h8000_0000,
    parameter int          ADRES_BIT       = 32,
    parameter int          VERI_BIT        = 32,
    parameter int          FIFO_DERINLIK   = 2
) (
    input  wire logic                               clk,
    input  wire logic                               rst,
    buyruk_getir_if.master                          bus,
    output logic [$clog2(FIFO_DERINLIK):0]          doluluk,
    output logic [31:0]                             getirilen_sayisi
);

    localparam int c_PTR_BIT   = $clog2(FIFO_DERINLIK);
    localparam int c_SAYAC_BIT = $clog2(FIFO_DERINLIK) + 1;
    localparam logic [c_SAYAC_BIT-1:0] c_DERINLIK = c_SAYAC_BIT'(FIFO_DERINLIK);
    localparam logic [ADRES_BIT-1:0]   c_BASLANGIC = ADRES_BIT'(BASLANGIC_ADRES);

    // Buffer storage; contents are meaningless unless covered by r_sayac.
    logic [ADRES_BIT-1:0]   r_pc_mem   [FIFO_DERINLIK];
    logic [VERI_BIT-1:0]    r_veri_mem [FIFO_DERINLIK];

    logic [ADRES_BIT-1:0]   r_getir_pc;
    logic [c_PTR_BIT-1:0]   r_wr_ptr;
    logic [c_PTR_BIT-1:0]   r_rd_ptr;
    logic [c_SAYAC_BIT-1:0] r_sayac;
    logic [31:0]            r_getirilen_sayisi;

    logic                   w_ekle;
    logic                   w_cikar;
    logic                   w_gecerli;
    logic [1:0]             w_unused_alt_bitler;

    // Redirect target is word aligned; its low bits are deliberately dropped.
    assign w_unused_alt_bitler = bus.yonlendir_adres[1:0];

    // Fetch only when the buffer has room; no bypass around a full buffer.
    assign w_ekle    = !rst && !bus.yonlendir && (r_sayac < c_DERINLIK);
    // A redirect hides the head so the core never consumes a stale word.
    assign w_gecerli = (r_sayac != '0) && !bus.yonlendir && !rst;
    assign w_cikar   = w_gecerli && bus.buyruk_hazir;

    assign bus.bellek_adres     = r_getir_pc;
    assign bus.bellek_oku_istek = w_ekle;
    assign bus.buyruk           = r_veri_mem[r_rd_ptr];
    assign bus.buyruk_pc        = r_pc_mem[r_rd_ptr];
    assign bus.buyruk_gecerli   = w_gecerli;
    assign doluluk              = r_sayac;
    assign getirilen_sayisi     = r_getirilen_sayisi;

    // Capture the fetched word and its address into the tail slot.
    always_ff @(posedge clk) begin
        if (w_ekle) begin
            r_pc_mem[r_wr_ptr]   <= r_getir_pc;
            r_veri_mem[r_wr_ptr] <= bus.bellek_oku_veri;
        end
    end

    // Fetch PC, pointers, occupancy and push counter; reset > redirect > normal.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_getir_pc         <= c_BASLANGIC;
            r_wr_ptr           <= '0;
            r_rd_ptr           <= '0;
            r_sayac            <= '0;
            r_getirilen_sayisi <= '0;
        end else if (bus.yonlendir) begin
            r_getir_pc <= {bus.yonlendir_adres[ADRES_BIT-1:2], 2'b00};
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_sayac    <= '0;
        end else begin
            if (w_ekle) begin
                r_getir_pc         <= r_getir_pc + ADRES_BIT'(4);
                r_wr_ptr           <= r_wr_ptr + c_PTR_BIT'(1);
                r_getirilen_sayisi <= r_getirilen_sayisi + 32'd1;
            end
            if (w_cikar) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_BIT'(1);
            end
            if (w_ekle && !w_cikar) begin
                r_sayac <= r_sayac + c_SAYAC_BIT'(1);
            end else if (!w_ekle && w_cikar) begin
                r_sayac <= r_sayac - c_SAYAC_BIT'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_buyruk_getir.sv
`default_nettype none
// ============================================================================
//  Module      : tb_buyruk_getir
//  Description : Self-checking bench for buyruk_getir with a queue-based
//                reference model of the fetch buffer and a synthetic memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_buyruk_getir;

    localparam int          DERINLIK = 2;
    localparam logic [31:0] BASLANGIC = 32'h8000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] w;
    } giris_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        yon = 1'b0;
    logic [31:0] yon_adres = '0;
    logic        hazir = 1'b0;
    logic [1:0]  doluluk;
    logic [31:0] getirilen_sayisi;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    giris_t      m_q[$];
    logic [31:0] m_pc  = BASLANGIC;
    logic [31:0] m_cnt = '0;

    buyruk_getir_if #(.ADRES_BIT(32), .VERI_BIT(32)) bus ();

    buyruk_getir #(
        .BASLANGIC_ADRES (BASLANGIC),
        .ADRES_BIT       (32),
        .VERI_BIT        (32),
        .FIFO_DERINLIK   (DERINLIK)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus.master),
        .doluluk          (doluluk),
        .getirilen_sayisi (getirilen_sayisi)
    );

    always #5 clk = ~clk;

    // Synthetic memory contents: two known words, hashed address elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'haae00893;
        if (a == 32'h8000_0004) return 32'h17200e93;
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    assign bus.bellek_oku_veri  = mem_word(bus.bellek_adres);
    assign bus.buyruk_hazir     = hazir;
    assign bus.yonlendir        = yon;
    assign bus.yonlendir_adres  = yon_adres;

    task automatic drive(input logic r, input logic y, input logic [31:0] ya, input logic h);
        rst = r; yon = y; yon_adres = ya; hazir = h;
        #1;
    endtask

    // Advance one clock and apply the same edge to the reference model.
    task automatic clk_edge();
        bit g, e;
        g = !rst && !yon && (m_q.size() > 0);
        e = !rst && !yon && (m_q.size() < DERINLIK);
        @(posedge clk);
        if (rst) begin
            m_q.delete(); m_pc = BASLANGIC; m_cnt = '0;
        end else if (yon) begin
            m_q.delete(); m_pc = {yon_adres[31:2], 2'b00};
        end else begin
            if (g && hazir) void'(m_q.pop_front());
            if (e) begin
                m_q.push_back('{pc: m_pc, w: mem_word(m_pc)});
                m_pc  = m_pc + 32'd4;
                m_cnt = m_cnt + 32'd1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        drive(1, 0, '0, 1);
        clk_edge(); clk_edge();
        n_total++; if (doluluk !== 2'd0) $display("FAIL rst_doluluk: got %0d want 0", doluluk); else n_pass++;
        n_total++; if (bus.buyruk_gecerli !== 1'b0) $display("FAIL rst_gecerli: got %b want 0", bus.buyruk_gecerli); else n_pass++;
        n_total++; if (bus.bellek_oku_istek !== 1'b0) $display("FAIL rst_istek: got %b want 0", bus.bellek_oku_istek); else n_pass++;
        n_total++; if (bus.bellek_adres !== BASLANGIC) $display("FAIL rst_adres: got %h want %h", bus.bellek_adres, BASLANGIC); else n_pass++;
        n_total++; if (getirilen_sayisi !== 32'd0) $display("FAIL rst_sayi: got %0d want 0", getirilen_sayisi); else n_pass++;
    endtask

    task automatic test_reset_fetch();
        drive(0, 0, '0, 1);
        n_total++; if (bus.bellek_oku_istek !== 1'b1 || bus.bellek_adres !== 32'h8000_0000)
            $display("FAIL fetch_first_req: got istek=%b adres=%h want 1/80000000", bus.bellek_oku_istek, bus.bellek_adres); else n_pass++;
        n_total++; if (bus.buyruk_gecerli !== 1'b0) $display("FAIL fetch_first_gecerli: got %b want 0", bus.buyruk_gecerli); else n_pass++;
        clk_edge();
        n_total++; if (bus.buyruk_gecerli !== 1'b1 || bus.buyruk !== 32'haae00893 || bus.buyruk_pc !== 32'h8000_0000)
            $display("FAIL fetch_c1: got v=%b %h@%h want 1 aae00893@80000000", bus.buyruk_gecerli, bus.buyruk, bus.buyruk_pc); else n_pass++;
        n_total++; if (getirilen_sayisi !== 32'd1) $display("FAIL fetch_c1_sayi: got %0d want 1", getirilen_sayisi); else n_pass++;
        clk_edge();
        n_total++; if (bus.buyruk_gecerli !== 1'b1 || bus.buyruk !== 32'h17200e93 || bus.buyruk_pc !== 32'h8000_0004)
            $display("FAIL fetch_c2: got v=%b %h@%h want 1 17200e93@80000004", bus.buyruk_gecerli, bus.buyruk, bus.buyruk_pc); else n_pass++;
        n_total++; if (getirilen_sayisi !== 32'd2) $display("FAIL fetch_c2_sayi: got %0d want 2", getirilen_sayisi); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_pc;
        drive(1, 0, '0, 0); clk_edge();
        drive(0, 0, '0, 0);
        n_total++; if (doluluk !== 2'd0) $display("FAIL bp_d0: got %0d want 0", doluluk); else n_pass++;
        clk_edge();
        n_total++; if (doluluk !== 2'd1) $display("FAIL bp_d1: got %0d want 1", doluluk); else n_pass++;
        clk_edge();
        n_total++; if (doluluk !== 2'd2) $display("FAIL bp_d2: got %0d want 2", doluluk); else n_pass++;
        n_total++; if (bus.bellek_oku_istek !== 1'b0) $display("FAIL bp_full_istek: got %b want 0", bus.bellek_oku_istek); else n_pass++;
        clk_edge();
        n_total++; if (doluluk !== 2'd2 || bus.bellek_adres !== 32'h8000_0008)
            $display("FAIL bp_hold: got d=%0d adres=%h want 2/80000008", doluluk, bus.bellek_adres); else n_pass++;
        drive(0, 0, '0, 1);
        for (int i = 0; i < 3; i++) begin
            exp_pc = 32'h8000_0000 + 32'(4 * i);
            n_total++; if (bus.buyruk_gecerli !== 1'b1 || bus.buyruk_pc !== exp_pc || bus.buyruk !== mem_word(exp_pc))
                $display("FAIL bp_pop%0d: got v=%b %h@%h want 1 %h@%h", i, bus.buyruk_gecerli, bus.buyruk, bus.buyruk_pc, mem_word(exp_pc), exp_pc);
            else n_pass++;
            clk_edge();
        end
    endtask

    task automatic test_redirect();
        drive(1, 0, '0, 1); clk_edge();
        drive(0, 0, '0, 1);
        for (int i = 0; i < 4; i++) clk_edge();
        drive(0, 1, 32'h8000_0012, 1);
        n_total++; if (bus.buyruk_gecerli !== 1'b0) $display("FAIL redir_c0_gecerli: got %b want 0", bus.buyruk_gecerli); else n_pass++;
        clk_edge();
        drive(0, 0, '0, 1);
        n_total++; if (bus.buyruk_gecerli !== 1'b0 || bus.bellek_adres !== 32'h8000_0010)
            $display("FAIL redir_c1: got v=%b adres=%h want 0/80000010", bus.buyruk_gecerli, bus.bellek_adres); else n_pass++;
        clk_edge();
        n_total++; if (bus.buyruk_gecerli !== 1'b1 || bus.buyruk_pc !== 32'h8000_0010 || bus.buyruk !== mem_word(32'h8000_0010))
            $display("FAIL redir_head: got v=%b %h@%h want 1 %h@80000010", bus.buyruk_gecerli, bus.buyruk, bus.buyruk_pc, mem_word(32'h8000_0010)); else n_pass++;
    endtask

    task automatic test_simultaneous();
        logic [31:0] sayi_once;
        n_total++; if (doluluk !== 2'd1) $display("FAIL sim_pushpop_pre: got %0d want 1", doluluk); else n_pass++;
        clk_edge();
        n_total++; if (doluluk !== 2'd1 || bus.buyruk_pc !== 32'h8000_0014)
            $display("FAIL sim_pushpop: got d=%0d pc=%h want 1/80000014", doluluk, bus.buyruk_pc); else n_pass++;
        drive(0, 1, 32'h8000_0040, 1);
        sayi_once = getirilen_sayisi;
        n_total++; if (bus.buyruk_gecerli !== 1'b0) $display("FAIL sim_redir_gecerli: got %b want 0", bus.buyruk_gecerli); else n_pass++;
        clk_edge();
        n_total++; if (doluluk !== 2'd0 || getirilen_sayisi !== sayi_once)
            $display("FAIL sim_redir_flush: got d=%0d sayi=%0d want 0/%0d", doluluk, getirilen_sayisi, sayi_once); else n_pass++;
    endtask

    task automatic test_mid_reset();
        drive(0, 1, 32'h8000_0018, 0); clk_edge();
        drive(0, 0, '0, 0); clk_edge(); clk_edge();
        n_total++; if (doluluk !== 2'd2 || bus.bellek_adres !== 32'h8000_0020)
            $display("FAIL mrst_pre: got d=%0d adres=%h want 2/80000020", doluluk, bus.bellek_adres); else n_pass++;
        drive(1, 0, '0, 0); clk_edge();
        n_total++; if (doluluk !== 2'd0 || bus.buyruk_gecerli !== 1'b0 || getirilen_sayisi !== 32'd0)
            $display("FAIL mrst_state: got d=%0d v=%b sayi=%0d want 0/0/0", doluluk, bus.buyruk_gecerli, getirilen_sayisi); else n_pass++;
        drive(0, 0, '0, 1);
        n_total++; if (bus.bellek_adres !== 32'h8000_0000 || bus.bellek_oku_istek !== 1'b1)
            $display("FAIL mrst_restart: got adres=%h istek=%b want 80000000/1", bus.bellek_adres, bus.bellek_oku_istek); else n_pass++;
        clk_edge();
    endtask

    task automatic test_pc_wrap();
        drive(0, 1, 32'hFFFF_FFFC, 1); clk_edge();
        drive(0, 0, '0, 1); clk_edge();
        n_total++; if (bus.buyruk_gecerli !== 1'b1 || bus.buyruk_pc !== 32'hFFFF_FFFC)
            $display("FAIL wrap_c0: got v=%b pc=%h want 1/fffffffc", bus.buyruk_gecerli, bus.buyruk_pc); else n_pass++;
        clk_edge();
        n_total++; if (bus.buyruk_gecerli !== 1'b1 || bus.buyruk_pc !== 32'h0000_0000 || bus.buyruk !== mem_word(32'h0))
            $display("FAIL wrap_c1: got v=%b %h@%h want 1 %h@00000000", bus.buyruk_gecerli, bus.buyruk, bus.buyruk_pc, mem_word(32'h0)); else n_pass++;
    endtask

    task automatic test_random();
        logic        r, y, h, exp_g, exp_e;
        logic [31:0] ya;
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 49) == 0);
            y  = ($urandom_range(0, 9) == 0);
            h  = ($urandom_range(0, 2) != 0);
            ya = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            drive(r, y, ya, h);
            exp_g = !r && !y && (m_q.size() > 0);
            exp_e = !r && !y && (m_q.size() < DERINLIK);
            n_total++; if (bus.buyruk_gecerli !== exp_g || bus.bellek_oku_istek !== exp_e)
                $display("FAIL rnd%0d_ctl: got v=%b istek=%b want %b/%b", i, bus.buyruk_gecerli, bus.bellek_oku_istek, exp_g, exp_e); else n_pass++;
            n_total++; if (bus.bellek_adres !== m_pc || doluluk !== 2'(m_q.size()) || getirilen_sayisi !== m_cnt)
                $display("FAIL rnd%0d_state: got adres=%h d=%0d sayi=%0d want %h/%0d/%0d", i, bus.bellek_adres, doluluk, getirilen_sayisi, m_pc, m_q.size(), m_cnt); else n_pass++;
            if (exp_g) begin
                n_total++; if (bus.buyruk !== m_q[0].w || bus.buyruk_pc !== m_q[0].pc)
                    $display("FAIL rnd%0d_head: got %h@%h want %h@%h", i, bus.buyruk, bus.buyruk_pc, m_q[0].w, m_q[0].pc); else n_pass++;
            end
            clk_edge();
        end
    endtask

    initial begin
        test_reset();
        test_reset_fetch();
        test_backpressure();
        test_redirect();
        test_simultaneous();
        test_mid_reset();
        test_pc_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/buyruk_getir.md
Name: buyruk_getir

Overview:
- Instruction-fetch front end that sits directly upstream of the `islemci` decode/execute path.
- Sequentially reads instruction words from `anabellek` over the read-only port and buffers them in a small FIFO.
- Presents them to the core with a valid/ready handshake together with their PC.
- Accepts a redirect (branch/jump target) that flushes the buffer and restarts fetch.

Parameters:
- BASLANGIC_ADRES, 32'h8000_0000, PC loaded on reset.
- ADRES_BIT, 32, address width.
- VERI_BIT, 32, instruction/data width.
- FIFO_DERINLIK, 2, buffer entries; power of two, ≥ 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- bellek_adres  output  ADRES_BIT  fetch address to `anabellek`.
- bellek_oku_istek  output  1  fetch request; the word on bellek_oku_veri is captured only when high.
- bellek_oku_veri  input  VERI_BIT  combinational read data for bellek_adres, valid in the same cycle.
- buyruk  output  VERI_BIT  instruction at FIFO head.
- buyruk_pc  output  ADRES_BIT  address of the head instruction.
- buyruk_gecerli  output  1  head valid.
- buyruk_hazir  input  1  core accepts the head.
- yonlendir  input  1  redirect request (one-cycle pulse or held).
- yonlendir_adres  input  ADRES_BIT  redirect target.
- doluluk  output  $clog2(FIFO_DERINLIK)+1  current FIFO occupancy.
- getirilen_sayisi  output  32  count of words pushed since reset.

Behaviour:
- **State.**
  - getir_pc_r: next fetch address.
  - FIFO of {pc, instruction} pairs with rd/wr pointers.
  - sayac_r: occupancy.
  - getirilen_sayisi_r.
- **Reset** (rst high at an edge):
  - getir_pc_r = BASLANGIC_ADRES.
  - FIFO empty (pointers 0, doluluk = 0).
  - getirilen_sayisi = 0.
  - While rst is high, bellek_oku_istek = 0 and buyruk_gecerli = 0.
  - bellek_adres = getir_pc_r; buyruk and buyruk_pc are don't-care when invalid.
  - Reset asserted mid-operation discards buffered words; no partial state survives.
- **Push condition (ekle)** = !rst && !yonlendir && (sayac_r < FIFO_DERINLIK).
  - bellek_oku_istek = ekle.
  - On the edge: the FIFO stores {getir_pc_r, bellek_oku_veri}, getir_pc_r += 4, and getirilen_sayisi += 1 (wraps modulo 2^32).
- **Pop condition (cikar)** = buyruk_gecerli && buyruk_hazir.
  - buyruk_gecerli = (sayac_r != 0) && !yonlendir && !rst.
  - buyruk and buyruk_pc come straight from FIFO head storage, with no combinational path from bellek_oku_veri.
- **Full/empty.**
  - Push and pop in the same cycle: sayac_r is unchanged and pointers advance independently.
  - Full: no push, even if a pop happens in the same cycle; no bypass.
  - Empty: buyruk_gecerli = 0; buyruk_hazir is ignored.
  - Pointers wrap modulo FIFO_DERINLIK.
- **Redirect** (yonlendir high at an edge):
  - Highest priority after rst.
  - FIFO flushed (sayac_r = 0).
  - getir_pc_r = {yonlendir_adres[ADRES_BIT-1:2], 2'b00}; the low two bits are ignored.
  - No push and no pop in that cycle: buyruk_gecerli is forced low, so the core sees no transfer.
  - Held redirect: each cycle reloads getir_pc_r.
- **Latency.**
  - First request is in the first cycle after rst falls; the word is valid at the head one cycle later.
  - Redirect to valid head is 2 cycles: the redirect cycle, then the fetch cycle.
  - Steady-state throughput with buyruk_hazir = 1 is one instruction per cycle.
- **Arithmetic.**
  - PC increment is unsigned ADRES_BIT-bit and wraps from 32'hFFFF_FFFC to 0.
  - No alignment or range fault is raised; out-of-range addresses are the memory's concern.

Test Plan:
- **Reset fetch.** Memory holds 32'haae00893 @80000000 and 32'h17200e93 @80000004; release rst, hazir = 1.
  - Cycle 1: buyruk = aae00893, pc = 80000000.
  - Cycle 2: buyruk = 17200e93, pc = 80000004.
  - getirilen_sayisi increments once per cycle.
- **Backpressure/full.** Hold hazir = 0 from release.
  - doluluk goes 1 then 2 and holds.
  - bellek_oku_istek = 0 once full; getir_pc_r stays at 80000008.
  - Raise hazir: words pop in order 80000000, 80000004, 80000008 with no loss or duplication.
- **Redirect.** After 3 words, pulse yonlendir with adres = 32'h8000_0012.
  - Next fetch address is 80000010.
  - buyruk_gecerli is low for exactly 2 cycles, then pc = 80000010.
  - Stale words are never presented.
- **Simultaneous events.** Redirect in the same cycle as hazir = 1 with a valid head: no pop counted and FIFO flushed. Push and pop in the same cycle with doluluk = 1: doluluk stays 1.
- **Mid-operation reset.** Assert rst with doluluk = 2 and PC = 80000020.
  - Next cycle: doluluk = 0, gecerli = 0, getirilen_sayisi = 0.
  - After release, fetch restarts at 80000000.
- **PC wrap.** Redirect to FFFFFFFC.
  - Heads arrive with pc FFFFFFFC, then 00000000.
